// File: rtl/wb_master_port.sv
// Wishbone classic single-transfer initiator: one valid/ready request becomes one bus cycle and one response pulse.
// Optional bus watchdog is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_port #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    // request / response port
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    input  logic [SEL_WIDTH-1:0]     req_sel_i,
    output logic                     rsp_valid_o,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic                     rsp_timeout_o,
    // Wishbone initiator
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [ADDRESS_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0]    dat_o,
    output logic [SEL_WIDTH-1:0]     sel_o,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    input  logic                     ack_i,
    input  logic                     err_i,
    input  logic                     rty_i
);

    // state   | meaning
    // IDLE    | ready for a request
    // BUS     | cyc/stb asserted, waiting for a termination
    // BACKOFF | one idle cycle after a retry termination
    // RESP    | one-cycle response pulse
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUS     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [1:0]               state_q, state_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [RW-1:0]            retry_q, retry_d;
    logic                     err_q, err_d;
    logic                     tmo_q, tmo_d;
    logic                     tmo_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timer_q, timer_d;

    // Down-counter reloaded outside BUS; terminal count means the budget is spent.
    always_comb begin
        timer_d = timer_q;
        if (state_q == S_IDLE || state_q == S_BACKOFF) begin
            timer_d = TMO_LOAD;
        end else if (state_q == S_BUS && timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end
    end

    assign tmo_hit = (state_q == S_BUS) && (timer_q == 16'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_q <= TMO_LOAD;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        retry_d = retry_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    adr_d   = req_addr_i;
                    wdat_d  = req_wdata_i;
                    sel_d   = req_sel_i;
                    retry_d = '0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // err beats ack beats rty when a slave drives several at once
                if (err_i) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (ack_i) begin
                    if (!we_q) begin
                        rdata_d = dat_i;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (rty_i) begin
                    if (retry_q == RETRY_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_BACKOFF;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_BACKOFF: state_d = S_BUS;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Decoded from state_q so an async reset drops cyc/stb at once.
    assign req_ready_o   = (state_q == S_IDLE);
    assign cyc_o         = (state_q == S_BUS);
    assign stb_o         = (state_q == S_BUS);
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = wdat_q;
    assign sel_o         = sel_q;
    assign rsp_valid_o   = (state_q == S_RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = (state_q == S_RESP) && err_q;
    assign rsp_timeout_o = (state_q == S_RESP) && tmo_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Scoreboard bench for wb_master_port with a behavioural Wishbone slave; timeout checks follow WB_MASTER_TIMEOUT_EN.
module tb_wb_master_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    localparam int M_ACK  = 0;
    localparam int M_ROM  = 1;
    localparam int M_RTY  = 2;
    localparam int M_NONE = 3;
    localparam int M_JUNK = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready_o, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_sel;
    logic          rsp_valid_o, rsp_err_o, rsp_timeout_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_i;
    logic          ack_i, err_i, rty_i;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_rdata;
    int            vectors = 0;
    int            miscompares = 0;

    int            mode = M_ACK;
    int            wait_n = 0;
    int            ack_after = 0;
    int            phase_cyc;
    int            attempts;
    logic [DW-1:0] slave_data = '0;
    logic          addr_mix = 1'b0;

    always #5 clk = ~clk;

    wb_master_port #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MAX_RETRY     (3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_sel_i    (req_sel),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .sel_o        (sel_o),
        .dat_i        (dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .rty_i        (rty_i)
    );

    // Behavioural slave: terminations are combinational from stb_o.
    always_comb begin
        ack_i = 1'b0;
        err_i = 1'b0;
        rty_i = 1'b0;
        if (mode == M_JUNK) begin
            ack_i = 1'b1;
            err_i = 1'b1;
            rty_i = 1'b1;
        end else if (stb_o) begin
            case (mode)
                M_ACK: ack_i = (phase_cyc == wait_n);
                M_ROM: begin
                    if (we_o) err_i = 1'b1;
                    else      ack_i = 1'b1;
                end
                M_RTY: begin
                    if (attempts == ack_after) ack_i = 1'b1;
                    else                       rty_i = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dat_i = addr_mix ? (slave_data ^ adr_o) : slave_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cyc <= 0;
            attempts  <= 0;
        end else begin
            if (stb_o && !ack_i && !err_i && !rty_i) phase_cyc <= phase_cyc + 1;
            else                                     phase_cyc <= 0;
            if (rsp_valid_o)         attempts <= 0;
            else if (stb_o && rty_i) attempts <= attempts + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_sel   = s;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int lat, output int ncyc, output int nphase);
        logic prev;
        prev = 1'b0;
        lat = 0;
        ncyc = 0;
        nphase = 0;
        do begin
            @(negedge clk);
            lat++;
            if (cyc_o) begin
                ncyc++;
                if (!prev) nphase++;
            end
            prev = cyc_o;
        end while (!rsp_valid_o && lat < limit);
    endtask

    task automatic pop_exp(output exp_t e, output logic ok);
        ok = (exp_q.size() != 0);
        e  = '0;
        if (ok) e = exp_q.pop_front();
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_sel = '0;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({req_ready_o, cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy/cyc/stb/we/val/err/tmo=%b want 1000000",
                     {req_ready_o, cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o});
        end
        vectors++;
        if ({adr_o, dat_o, sel_o, rsp_rdata_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got adr=%h dat=%h sel=%h rdata=%h want all 0", adr_o, dat_o, sel_o, rsp_rdata_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({req_ready_o, cyc_o, rsp_valid_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_release: got rdy/cyc/val=%b want 100", {req_ready_o, cyc_o, rsp_valid_o});
        end
        e = '0;
    endtask

    task automatic test_read_comb;
        exp_t e;
        logic ok;
        mode = M_ACK;
        wait_n = 0;
        addr_mix = 1'b0;
        slave_data = 32'h8765_4321;
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL read_ready: got %b want 1", req_ready_o);
        end
        model_rdata = 32'h8765_4321;
        exp_q.push_back('{model_rdata, 1'b0, 1'b0});
        drive_req(1'b0, 32'h4, 32'h0, 4'hF);
        @(negedge clk);
        vectors++;
        if ({cyc_o, stb_o, req_ready_o, we_o, adr_o} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h4}) begin
            miscompares++;
            $display("FAIL read_bus: got cyc=%b stb=%b rdy=%b we=%b adr=%h want 1 1 0 0 00000004",
                     cyc_o, stb_o, req_ready_o, we_o, adr_o);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid_o, cyc_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL read_latency: got val=%b cyc=%b want val=1 cyc=0", rsp_valid_o, cyc_o);
        end
        pop_exp(e, ok);
        vectors++;
        if (!ok || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
            miscompares++;
            $display("FAIL read_rsp: got rdata=%h err=%b tmo=%b want rdata=%h err=%b tmo=%b",
                     rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
        @(negedge clk);
        vectors++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL read_after: got rdy/val/err=%b want 100", {req_ready_o, rsp_valid_o, rsp_err_o});
        end
    endtask

    task automatic test_write_wait;
        exp_t e;
        logic ok;
        int lat, ncyc;
        mode = M_ACK;
        wait_n = 3;
        exp_q.push_back('{model_rdata, 1'b0, 1'b0});
        drive_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        lat = 0;
        ncyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (cyc_o) begin
                ncyc++;
                vectors++;
                if ({we_o, adr_o, dat_o, sel_o} !== {1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
                    miscompares++;
                    $display("FAIL write_stable: got we=%b adr=%h dat=%h sel=%h want 1 00001000 deadbeef f",
                             we_o, adr_o, dat_o, sel_o);
                end
            end
        end while (!rsp_valid_o && lat < 20);
        vectors++;
        if (ncyc !== 4 || lat !== 5) begin
            miscompares++;
            $display("FAIL write_cycles: got cyc_cycles=%0d latency=%0d want 4 and 5", ncyc, lat);
        end
        pop_exp(e, ok);
        vectors++;
        if (!ok || rsp_valid_o !== 1'b1 || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
            miscompares++;
            $display("FAIL write_rsp: got val=%b rdata=%h err=%b tmo=%b want val=1 rdata=%h err=%b tmo=%b",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
        @(negedge clk);
    endtask

    task automatic test_rom_error;
        exp_t e;
        logic ok;
        int lat, ncyc, nph;
        mode = M_ROM;
        slave_data = 32'h0BAD_F00D;
        model_rdata = 32'h0BAD_F00D;
        exp_q.push_back('{model_rdata, 1'b0, 1'b0});
        drive_req(1'b0, 32'h0, 32'h0, 4'hF);
        wait_rsp(20, lat, ncyc, nph);
        pop_exp(e, ok);
        vectors++;
        if (!ok || rsp_valid_o !== 1'b1 || lat !== 2 || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
            miscompares++;
            $display("FAIL rom_read: got val=%b lat=%0d rdata=%h err=%b tmo=%b want val=1 lat=2 rdata=%h err=%b tmo=%b",
                     rsp_valid_o, lat, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
        @(negedge clk);
        slave_data = 32'h1111_2222;
        exp_q.push_back('{model_rdata, 1'b1, 1'b0});
        drive_req(1'b1, 32'h8, 32'h5555_AAAA, 4'h3);
        wait_rsp(20, lat, ncyc, nph);
        pop_exp(e, ok);
        vectors++;
        if (!ok || rsp_valid_o !== 1'b1 || lat !== 2 || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
            miscompares++;
            $display("FAIL rom_write_err: got val=%b lat=%0d rdata=%h err=%b tmo=%b want val=1 lat=2 rdata=%h err=%b tmo=%b",
                     rsp_valid_o, lat, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
        @(negedge clk);
    endtask

    task automatic test_retry;
        exp_t e;
        logic ok;
        int lat, ncyc, nph;
        mode = M_RTY;
        ack_after = 99;
        slave_data = 32'hFFFF_0000;
        exp_q.push_back('{model_rdata, 1'b1, 1'b0});
        drive_req(1'b0, 32'h20, 32'h0, 4'hF);
        wait_rsp(40, lat, ncyc, nph);
        vectors++;
        if (nph !== 4 || ncyc !== 4 || lat !== 8) begin
            miscompares++;
            $display("FAIL retry_exhaust_phases: got phases=%0d cyc_cycles=%0d latency=%0d want 4 4 8", nph, ncyc, lat);
        end
        pop_exp(e, ok);
        vectors++;
        if (!ok || rsp_valid_o !== 1'b1 || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
            miscompares++;
            $display("FAIL retry_exhaust_rsp: got val=%b rdata=%h err=%b tmo=%b want val=1 rdata=%h err=%b tmo=%b",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
        @(negedge clk);
        ack_after = 2;
        slave_data = 32'h1357_9BDF;
        model_rdata = 32'h1357_9BDF;
        exp_q.push_back('{model_rdata, 1'b0, 1'b0});
        drive_req(1'b0, 32'h24, 32'h0, 4'hF);
        wait_rsp(40, lat, ncyc, nph);
        vectors++;
        if (nph !== 3 || ncyc !== 3 || lat !== 6) begin
            miscompares++;
            $display("FAIL retry_ack3_phases: got phases=%0d cyc_cycles=%0d latency=%0d want 3 3 6", nph, ncyc, lat);
        end
        pop_exp(e, ok);
        vectors++;
        if (!ok || rsp_valid_o !== 1'b1 || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
            miscompares++;
            $display("FAIL retry_ack3_rsp: got val=%b rdata=%h err=%b tmo=%b want val=1 rdata=%h err=%b tmo=%b",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic ok;
        int k, sent, rsp_cnt, last_k;
        logic [3:0] we_pat;
        mode = M_ACK;
        wait_n = 0;
        addr_mix = 1'b1;
        slave_data = 32'hA5A5_0000;
        we_pat = 4'b0010;
        k = 0;
        sent = 0;
        rsp_cnt = 0;
        last_k = -1;
        while (rsp_cnt < 4 && k < 40) begin
            req_valid = 1'b0;
            if (rsp_valid_o) begin
                pop_exp(e, ok);
                vectors++;
                if (!ok || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
                    miscompares++;
                    $display("FAIL b2b_rsp%0d: got rdata=%h err=%b tmo=%b want rdata=%h err=%b tmo=%b",
                             rsp_cnt, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
                end
                if (rsp_cnt > 0) begin
                    vectors++;
                    if (k - last_k !== 3) begin
                        miscompares++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles want 3", rsp_cnt, k - last_k);
                    end
                end
                last_k = k;
                rsp_cnt++;
            end
            if (sent < 4 && req_ready_o) begin
                req_we    = we_pat[sent];
                req_addr  = 32'h100 + 32'(4 * sent);
                req_wdata = 32'hC0DE_0000 + 32'(sent);
                req_sel   = 4'hF;
                req_valid = 1'b1;
                if (!we_pat[sent]) model_rdata = slave_data ^ req_addr;
                exp_q.push_back('{model_rdata, 1'b0, 1'b0});
                sent++;
            end
            @(negedge clk);
            k++;
        end
        req_valid = 1'b0;
        addr_mix = 1'b0;
        vectors++;
        if (rsp_cnt !== 4 || last_k !== 11) begin
            miscompares++;
            $display("FAIL b2b_total: got responses=%0d last_at=%0d want 4 and 11", rsp_cnt, last_k);
        end
    endtask

    task automatic test_idle_junk;
        int seen;
        seen = 0;
        mode = M_JUNK;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid_o || cyc_o || !req_ready_o) seen++;
        end
        mode = M_ACK;
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL idle_junk: got %0d disturbed cycles want 0", seen);
        end
    endtask

    task automatic test_timeout;
        int lat, ncyc, nph;
`ifdef WB_MASTER_TIMEOUT_EN
        exp_t e;
        logic ok;
`else
        int bad;
`endif
        mode = M_NONE;
`ifdef WB_MASTER_TIMEOUT_EN
        exp_q.push_back('{model_rdata, 1'b1, 1'b1});
        drive_req(1'b0, 32'h40, 32'h0, 4'hF);
        wait_rsp(60, lat, ncyc, nph);
        vectors++;
        if (ncyc !== 16 || lat !== 17) begin
            miscompares++;
            $display("FAIL timeout_cycles: got cyc_cycles=%0d latency=%0d want 16 and 17", ncyc, lat);
        end
        pop_exp(e, ok);
        vectors++;
        if (!ok || rsp_valid_o !== 1'b1 || {rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
            miscompares++;
            $display("FAIL timeout_rsp: got val=%b rdata=%h err=%b tmo=%b want val=1 rdata=%h err=%b tmo=%b",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
        @(negedge clk);
`else
        drive_req(1'b0, 32'h40, 32'h0, 4'hF);
        bad = 0;
        lat = 0;
        ncyc = 0;
        nph = 0;
        repeat (40) begin
            @(negedge clk);
            if (!cyc_o || rsp_valid_o) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL no_timeout_hold: got %0d cycles with cyc low or response want 0", bad);
        end
`endif
    endtask

    task automatic test_reset_mid_bus;
        int seen;
        mode = M_NONE;
        if (!cyc_o) begin
            drive_req(1'b1, 32'h80, 32'h1234_5678, 4'hF);
            repeat (3) @(negedge clk);
        end
        vectors++;
        if (cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got cyc=%b want 1", cyc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({cyc_o, stb_o, rsp_valid_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid_async: got cyc/stb/val=%b want 000", {cyc_o, stb_o, rsp_valid_o});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_rdata = '0;
        exp_q.delete();
        mode = M_ACK;
        seen = 0;
        @(negedge clk);
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_ready: got %b want 1", req_ready_o);
        end
        repeat (5) begin
            if (rsp_valid_o) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 0 || rsp_rdata_o !== model_rdata) begin
            miscompares++;
            $display("FAIL rst_mid_norsp: got responses=%0d rdata=%h want 0 and %h", seen, rsp_rdata_o, model_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_read_comb();
        test_write_wait();
        test_rom_error();
        test_retry();
        test_back_to_back();
        test_idle_junk();
        test_timeout();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
